// File: rtl/processing_unit_gen2_if.sv
// Control-unit / memory boundary of processing_unit_gen2: load and select
// strobes flow in, architectural outputs and multiplier status flow back.
interface processing_unit_gen2_if #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_REGS  = 4
);
    localparam int SEL1_SIZE    = $clog2(NUM_REGS + 1);
    localparam int REG_SEL_SIZE = $clog2(NUM_REGS);

    logic [WORD_SIZE-1:0]    mem_word;
    logic                    load_reg;
    logic [REG_SEL_SIZE-1:0] load_reg_sel;
    logic                    load_pc;
    logic                    inc_pc;
    logic                    load_ir;
    logic                    load_add_r;
    logic                    load_reg_y;
    logic                    load_flags;
    logic [SEL1_SIZE-1:0]    sel_bus_1;
    logic [1:0]              sel_bus_2;
    logic                    alu_start;

    logic [WORD_SIZE-1:0]    instruction;
    logic [WORD_SIZE-1:0]    address;
    logic [WORD_SIZE-1:0]    bus_1;
    logic                    zflag;
    logic                    cflag;
    logic                    nflag;
    logic                    alu_busy;
    logic                    alu_done;

    modport master (
        output mem_word, load_reg, load_reg_sel, load_pc, inc_pc, load_ir,
               load_add_r, load_reg_y, load_flags, sel_bus_1, sel_bus_2, alu_start,
        input  instruction, address, bus_1, zflag, cflag, nflag, alu_busy, alu_done
    );

    modport slave (
        input  mem_word, load_reg, load_reg_sel, load_pc, inc_pc, load_ir,
               load_add_r, load_reg_y, load_flags, sel_bus_1, sel_bus_2, alu_start,
        output instruction, address, bus_1, zflag, cflag, nflag, alu_busy, alu_done
    );
endinterface

// File: rtl/processing_unit_gen2.sv
// RISC datapath: register file, PC, IR, address and Y registers, status flags
// and an ALU whose MUL opcode runs an iterative shift-add multiplier.
module processing_unit_gen2 #(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4,
    parameter int NUM_REGS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    processing_unit_gen2_if.slave bus
);
    localparam int SEL1_SIZE    = $clog2(NUM_REGS + 1);
    localparam int REG_SEL_SIZE = $clog2(NUM_REGS);
    localparam int COUNT_W      = $clog2(WORD_SIZE) + 1;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WORD_SIZE - 1);

    localparam logic [OP_SIZE-1:0] OP_NOP = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_NOT = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_OR  = OP_SIZE'(5);
    localparam logic [OP_SIZE-1:0] OP_XOR = OP_SIZE'(6);
    localparam logic [OP_SIZE-1:0] OP_SHL = OP_SIZE'(7);
    localparam logic [OP_SIZE-1:0] OP_SHR = OP_SIZE'(8);
    localparam logic [OP_SIZE-1:0] OP_MUL = OP_SIZE'(9);

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

    logic [WORD_SIZE-1:0]    regs [NUM_REGS];
    logic [WORD_SIZE-1:0]    pc;
    logic [WORD_SIZE-1:0]    ir;
    logic [WORD_SIZE-1:0]    add_r;
    logic [WORD_SIZE-1:0]    reg_y;
    logic                    zflag_q;
    logic                    cflag_q;
    logic                    nflag_q;

    logic [SEL1_SIZE-1:0]    sel1;
    logic [REG_SEL_SIZE-1:0] wr_sel;
    logic [OP_SIZE-1:0]      opcode;
    logic [WORD_SIZE-1:0]    bus_1_val;
    logic [WORD_SIZE-1:0]    bus_2_val;
    logic [WORD_SIZE-1:0]    alu_result;
    logic                    alu_carry;
    logic [WORD_SIZE:0]      sum;
    logic [WORD_SIZE:0]      diff;

    mul_state_t              state;
    mul_state_t              state_next;
    logic                    busy;
    logic                    done;
    logic                    start_accept;
    logic [2*WORD_SIZE-1:0]  mcand;
    logic [WORD_SIZE-1:0]    mplier;
    logic [2*WORD_SIZE-1:0]  prod;
    logic [COUNT_W-1:0]      count;

    assign sel1   = bus.sel_bus_1;
    assign wr_sel = bus.load_reg_sel;
    assign opcode = ir[WORD_SIZE-1 -: OP_SIZE];

    // Codes above NUM_REGS fall through to zero.
    always_comb begin
        bus_1_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(sel1) == i) bus_1_val = regs[i];
        end
        if (int'(sel1) == NUM_REGS) bus_1_val = pc;
    end

    always_comb begin
        case (bus.sel_bus_2)
            2'd0:    bus_2_val = alu_result;
            2'd1:    bus_2_val = bus_1_val;
            2'd2:    bus_2_val = bus.mem_word;
            default: bus_2_val = '0;
        endcase
    end

    assign sum  = {1'b0, reg_y} + {1'b0, bus_1_val};
    assign diff = {1'b0, reg_y} - {1'b0, bus_1_val};

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (opcode)
            OP_NOP: alu_result = bus_1_val;
            OP_ADD: {alu_carry, alu_result} = sum;
            OP_SUB: {alu_carry, alu_result} = diff;
            OP_AND: alu_result = reg_y & bus_1_val;
            OP_NOT: alu_result = ~bus_1_val;
            OP_OR:  alu_result = reg_y | bus_1_val;
            OP_XOR: alu_result = reg_y ^ bus_1_val;
            OP_SHL: begin
                alu_result = bus_1_val << 1;
                alu_carry  = bus_1_val[WORD_SIZE-1];
            end
            OP_SHR: begin
                alu_result = bus_1_val >> 1;
                alu_carry  = bus_1_val[0];
            end
            OP_MUL: begin
                alu_result = prod[WORD_SIZE-1:0];
                alu_carry  = |prod[2*WORD_SIZE-1:WORD_SIZE];
            end
            default: ;
        endcase
    end

    // Multiplier sequencer: a start is honoured in IDLE and in the DONE
    // cycle, so back-to-back multiplies lose no cycle.
    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        done         = 1'b0;
        start_accept = bus.alu_start && (opcode == OP_MUL) && (state != MUL_BUSY);
        case (state)
            MUL_IDLE: if (start_accept) state_next = MUL_BUSY;
            MUL_BUSY: begin
                busy = 1'b1;
                if (count == LAST_COUNT) state_next = MUL_DONE;
            end
            MUL_DONE: begin
                done       = 1'b1;
                state_next = start_accept ? MUL_BUSY : MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MUL_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (start_accept) begin
            mcand  <= {{WORD_SIZE{1'b0}}, reg_y};
            mplier <= bus_1_val;
            prod   <= '0;
            count  <= '0;
        end else if (busy) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + COUNT_W'(1);
        end
    end

    // NOTE: the register file is reset explicitly; it is small flop storage,
    // not a RAM macro, and software may rely on all registers reading zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.load_reg && int'(wr_sel) == i) regs[i] <= bus_2_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            ir      <= '0;
            add_r   <= '0;
            reg_y   <= '0;
            zflag_q <= 1'b0;
            cflag_q <= 1'b0;
            nflag_q <= 1'b0;
        end else begin
            if (bus.load_pc)      pc <= bus_2_val;
            else if (bus.inc_pc)  pc <= pc + WORD_SIZE'(1);
            if (bus.load_ir)      ir    <= bus_2_val;
            if (bus.load_add_r)   add_r <= bus_2_val;
            if (bus.load_reg_y)   reg_y <= bus_2_val;
            // Flags stay frozen while the product is still partial.
            if (bus.load_flags && !busy) begin
                zflag_q <= (alu_result == '0);
                cflag_q <= alu_carry;
                nflag_q <= alu_result[WORD_SIZE-1];
            end
        end
    end

    assign bus.instruction = ir;
    assign bus.address     = add_r;
    assign bus.bus_1       = bus_1_val;
    assign bus.zflag       = zflag_q;
    assign bus.cflag       = cflag_q;
    assign bus.nflag       = nflag_q;
    assign bus.alu_busy    = busy;
    assign bus.alu_done    = done;
endmodule

// File: tb/tb_processing_unit_gen2.sv
// Directed and randomized checks of processing_unit_gen2 against an
// arithmetic reference model of its architectural state.
module tb_processing_unit_gen2;
    localparam int W   = 8;
    localparam int NR  = 4;
    localparam int MOD = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    processing_unit_gen2_if #(.WORD_SIZE(W), .NUM_REGS(NR)) bus ();

    processing_unit_gen2 #(.WORD_SIZE(W), .OP_SIZE(4), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int m_r [NR];
    int m_pc, m_ir, m_ar, m_y, m_z, m_c, m_n, m_prod;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void alu_ref(input int op, input int a, input int b, input int p,
                                    output int res, output int carry);
        carry = 0;
        res   = 0;
        case (op)
            0: res = b;
            1: begin res = (a + b) % MOD; carry = (a + b >= MOD) ? 1 : 0; end
            2: begin res = (a - b + MOD) % MOD; carry = (a < b) ? 1 : 0; end
            3: res = a & b;
            4: res = (MOD - 1) - b;
            5: res = a | b;
            6: res = a ^ b;
            7: begin res = (b * 2) % MOD; carry = (b >= MOD / 2) ? 1 : 0; end
            8: begin res = b / 2; carry = b % 2; end
            9: begin res = p % MOD; carry = (p >= MOD) ? 1 : 0; end
            default: res = 0;
        endcase
    endfunction

    function automatic void set_flags(input int res, input int carry);
        m_z = (res == 0) ? 1 : 0;
        m_n = (res >= MOD / 2) ? 1 : 0;
        m_c = carry;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_r[i] = 0;
        m_pc = 0; m_ir = 0; m_ar = 0; m_y = 0;
        m_z = 0; m_c = 0; m_n = 0; m_prod = 0;
    endfunction

    task automatic idle();
        bus.mem_word     = '0;
        bus.load_reg     = 1'b0;
        bus.load_reg_sel = '0;
        bus.load_pc      = 1'b0;
        bus.inc_pc       = 1'b0;
        bus.load_ir      = 1'b0;
        bus.load_add_r   = 1'b0;
        bus.load_reg_y   = 1'b0;
        bus.load_flags   = 1'b0;
        bus.sel_bus_1    = '0;
        bus.sel_bus_2    = 2'd3;
        bus.alu_start    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_reg(input int idx, input int val);
        bus.mem_word = W'(val); bus.sel_bus_2 = 2'd2;
        bus.load_reg = 1'b1;    bus.load_reg_sel = idx[1:0];
        tick(); idle();
        m_r[idx] = val;
    endtask

    task automatic write_y(input int val);
        bus.mem_word = W'(val); bus.sel_bus_2 = 2'd2; bus.load_reg_y = 1'b1;
        tick(); idle();
        m_y = val;
    endtask

    task automatic write_ir(input int op);
        bus.mem_word = W'(op << (W - 4)); bus.sel_bus_2 = 2'd2; bus.load_ir = 1'b1;
        tick(); idle();
        m_ir = op << (W - 4);
    endtask

    task automatic check_sel(input string tag, input int sel, input int exp);
        bus.sel_bus_1 = sel[2:0];
        #1;
        check(tag, 32'(bus.bus_1), exp);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_z"}, 32'(bus.zflag), m_z);
        check({tag, "_c"}, 32'(bus.cflag), m_c);
        check({tag, "_n"}, 32'(bus.nflag), m_n);
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < NR; i++) check_sel($sformatf("%s_r%0d", tag, i), i, m_r[i]);
        check_sel({tag, "_pc"}, NR, m_pc);
        check({tag, "_ir"},   32'(bus.instruction), m_ir);
        check({tag, "_ar"},   32'(bus.address), m_ar);
        check({tag, "_busy"}, 32'(bus.alu_busy), 0);
        check({tag, "_done"}, 32'(bus.alu_done), 0);
        check_flags(tag);
    endtask

    task automatic alu_op(input string tag, input int op, input int a, input int b,
                          input int src, input int dst);
        int res, carry;
        write_reg(src, b); write_y(a); write_ir(op);
        alu_ref(op, m_y, m_r[src], m_prod, res, carry);
        bus.sel_bus_1 = src[2:0]; bus.sel_bus_2 = 2'd0;
        bus.load_reg = 1'b1; bus.load_reg_sel = dst[1:0]; bus.load_flags = 1'b1;
        tick(); idle();
        m_r[dst] = res;
        set_flags(res, carry);
        check_sel({tag, "_res"}, dst, m_r[dst]);
        check_flags(tag);
    endtask

    task automatic mul_start(input int a, input int b, input int src);
        write_reg(src, b); write_y(a); write_ir(9);
        bus.sel_bus_1 = src[2:0]; bus.alu_start = 1'b1;
        tick(); idle();
        m_prod = a * b;
    endtask

    // Waits out the busy phase; optionally pokes an illegal start plus
    // load_flags, and/or reloads Y, while the multiplier runs.
    task automatic mul_wait(input string tag, input bit poke, input int new_y);
        int cnt = 0;
        while (bus.alu_done !== 1'b1 && cnt < 20) begin
            check({tag, "_busy"}, 32'(bus.alu_busy), 1);
            cnt++;
            if (poke && cnt == 2) begin
                bus.alu_start = 1'b1; bus.sel_bus_1 = '0; bus.load_flags = 1'b1;
            end
            if (new_y >= 0 && cnt == 3) begin
                bus.mem_word = W'(new_y); bus.sel_bus_2 = 2'd2; bus.load_reg_y = 1'b1;
                m_y = new_y;
            end
            tick(); idle();
            if (poke && cnt == 2) check_flags({tag, "_hold"});
        end
        check({tag, "_len"},  cnt, W);
        check({tag, "_done"}, 32'(bus.alu_done), 1);
        check({tag, "_idle"}, 32'(bus.alu_busy), 0);
    endtask

    // In the done cycle: store the product in R3 with flags, optionally
    // launching the next multiply in the same cycle.
    task automatic mul_collect(input string tag, input int src, input bit chain);
        int res, carry, next_prod;
        alu_ref(9, 0, 0, m_prod, res, carry);
        next_prod = m_y * m_r[src];
        bus.sel_bus_1 = src[2:0]; bus.sel_bus_2 = 2'd0;
        bus.load_reg = 1'b1; bus.load_reg_sel = 2'd3; bus.load_flags = 1'b1;
        bus.alu_start = chain;
        tick(); idle();
        m_r[3] = res;
        set_flags(res, carry);
        if (chain) m_prod = next_prod;
        check({tag, "_pulse"}, 32'(bus.alu_done), 0);
        check({tag, "_chain"}, 32'(bus.alu_busy), 32'(chain));
        check_sel({tag, "_res"}, 3, m_r[3]);
        check_flags(tag);
    endtask

    initial begin
        int op, a, b, src, dst, seen;
        idle();
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_state("reset0");
        rst = 1'b1;
        @(negedge clk);

        alu_op("add_carry", 1, 8'hF0, 8'h20, 1, 2);
        alu_op("sub_zero",  2, 8'h55, 8'h55, 1, 2);
        alu_op("sub_borrow", 2, 8'h01, 8'h02, 1, 2);
        alu_op("shl_out", 7, 0, 8'h81, 0, 1);
        alu_op("shr_out", 8, 0, 8'h01, 0, 1);
        alu_op("op_hi",  12, 8'h33, 8'h44, 2, 0);

        for (int i = 0; i < 30; i++) begin
            op  = $urandom_range(0, 15);
            if (op == 9) op = 6;
            a   = $urandom_range(0, MOD - 1);
            b   = $urandom_range(0, MOD - 1);
            src = $urandom_range(0, NR - 1);
            dst = $urandom_range(0, NR - 1);
            alu_op($sformatf("rand%0d_op%0d", i, op), op, a, b, src, dst);
        end

        // PC wrap, load priority over increment, illegal bus_1 selects.
        bus.mem_word = 8'hFF; bus.sel_bus_2 = 2'd2; bus.load_pc = 1'b1;
        tick(); idle(); m_pc = 8'hFF;
        check_sel("pc_load", NR, m_pc);
        bus.inc_pc = 1'b1; tick(); idle(); m_pc = 0;
        check_sel("pc_wrap", NR, m_pc);
        bus.mem_word = 8'h40; bus.sel_bus_2 = 2'd2; bus.load_pc = 1'b1; bus.inc_pc = 1'b1;
        tick(); idle(); m_pc = 8'h40;
        check_sel("pc_prio", NR, m_pc);
        repeat (3) begin bus.inc_pc = 1'b1; tick(); idle(); end
        m_pc = 8'h43;
        check_sel("pc_inc", NR, m_pc);
        for (int s = NR + 1; s < 8; s++) check_sel($sformatf("sel%0d_zero", s), s, 0);

        // All loads share bus_2 in one cycle.
        bus.mem_word = 8'h3C; bus.sel_bus_2 = 2'd2;
        bus.load_reg = 1'b1; bus.load_reg_sel = 2'd2; bus.load_add_r = 1'b1; bus.load_ir = 1'b1;
        tick(); idle();
        m_r[2] = 8'h3C; m_ar = 8'h3C; m_ir = 8'h3C;
        check_state("multi_load");

        mul_start(13, 11, 1);
        mul_wait("mul_13x11", 1'b1, -1);
        mul_collect("mul_13x11", 1, 1'b0);

        mul_start(20, 20, 1);
        mul_wait("mul_20x20", 1'b0, 7);
        mul_collect("mul_20x20", 1, 1'b1);
        mul_wait("mul_b2b", 1'b0, -1);
        mul_collect("mul_b2b", 1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            a = $urandom_range(0, MOD - 1);
            b = $urandom_range(0, MOD - 1);
            mul_start(a, b, 2);
            mul_wait($sformatf("mul_rand%0d", i), 1'b0, -1);
            mul_collect($sformatf("mul_rand%0d", i), 2, 1'b0);
        end

        // Abort a multiply in its third busy cycle.
        bus.mem_word = 8'h5A; bus.sel_bus_2 = 2'd2; bus.load_add_r = 1'b1; bus.inc_pc = 1'b1;
        tick(); idle();
        mul_start(13, 11, 1);
        tick(); tick();
        check("abort_pre_busy", 32'(bus.alu_busy), 1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("abort_busy_drop", 32'(bus.alu_busy), 0);
        check_state("abort");
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.alu_done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);
        write_reg(0, 8'hAA);
        write_ir(9);
        bus.sel_bus_2 = 2'd0; bus.load_reg = 1'b1; bus.load_reg_sel = 2'd0;
        tick(); idle();
        m_r[0] = 0;
        check_sel("abort_prod_zero", 0, m_r[0]);

        mul_start(13, 11, 1);
        mul_wait("mul_after_abort", 1'b0, -1);
        mul_collect("mul_after_abort", 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
